// File: rtl/uart_pkg.sv
// Shared definitions for the UART byte receiver and the future transmitter:
// FSM state encoding, default clocking constants and the data width.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam int DEFAULT_CLK_FREQ = 50_000_000;
  localparam int DEFAULT_UART_BPS = 9600;
  localparam int DATA_BITS        = 8;

  // Even parity: the parity bit equals the XOR of the data bits.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] i_d);
    return ^i_d;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter with mid-bit and end-of-bit strobes; held at zero while
// i_clr is high so that bit timing restarts from the detected start edge.
module uart_baud_gen #(
  parameter int BAUD_CNT_MAX = 5208
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  output logic o_mid,
  output logic o_full
);

  localparam int CW = (BAUD_CNT_MAX > 2) ? $clog2(BAUD_CNT_MAX) : 1;
  localparam logic [CW-1:0] MID_CNT  = CW'(BAUD_CNT_MAX / 2 - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(BAUD_CNT_MAX - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || (r_cnt == LAST_CNT)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_mid  = !i_clr && (r_cnt == MID_CNT);
  assign o_full = !i_clr && (r_cnt == LAST_CNT);

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver producing one-cycle byte and framing-error strobes.
// Define UART_RX_PARITY_EN to receive 8E1 frames (even parity bit before stop).
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
  parameter int UART_BPS = DEFAULT_UART_BPS
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] po_data,
  output logic                 po_flag,
  output logic                 po_frame_err
);

  localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;

`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] ST_AFTER_DATA = ST_PARITY;
`else
  localparam logic [2:0] ST_AFTER_DATA = ST_STOP;
`endif

  logic                 r_rx1;
  logic                 r_rx2;
  logic                 r_rx3;
  logic [2:0]           r_state;
  logic [2:0]           r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 w_mid;
  logic                 w_full;
  logic                 w_start_edge;
  logic                 w_par_ok;

  // Synchronizer resets to the idle-high line level so release never looks like a start edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rx1 <= 1'b1;
      r_rx2 <= 1'b1;
      r_rx3 <= 1'b1;
    end else begin
      r_rx1 <= rx;
      r_rx2 <= r_rx1;
      r_rx3 <= r_rx2;
    end
  end

  assign w_start_edge = r_rx3 && !r_rx2;

  uart_baud_gen #(
    .BAUD_CNT_MAX(BAUD_CNT_MAX)
  ) u_baud (
    .i_clk  (sys_clk),
    .i_rst_n(sys_rst_n),
    .i_clr  (r_state == ST_IDLE),
    .o_mid  (w_mid),
    .o_full (w_full)
  );

`ifdef UART_RX_PARITY_EN
  logic r_par_err;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_par_err <= 1'b0;
    end else if ((r_state == ST_PARITY) && w_mid) begin
      r_par_err <= (even_parity(r_shift) != r_rx3);
    end
  end

  assign w_par_ok = !r_par_err;
`else
  assign w_par_ok = 1'b1;
`endif

  // State changes on bit boundaries (w_full) so every state sees exactly one mid-bit sample;
  // STOP is the exception and returns to IDLE at its sample to catch back-to-back frames.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      po_data      <= '0;
      po_flag      <= 1'b0;
      po_frame_err <= 1'b0;
    end else begin
      po_flag      <= 1'b0;
      po_frame_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_bit_cnt <= '0;
          if (w_start_edge) begin
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_mid && r_rx3) begin
            r_state <= ST_IDLE;
          end else if (w_full) begin
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_mid) begin
            r_shift <= {r_rx3, r_shift[DATA_BITS-1:1]};
          end
          if (w_full) begin
            if (r_bit_cnt == 3'(DATA_BITS - 1)) begin
              r_bit_cnt <= '0;
              r_state   <= ST_AFTER_DATA;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (w_full) begin
            r_state <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (w_mid) begin
            r_state <= ST_IDLE;
            if (r_rx3 && w_par_ok) begin
              po_data <= r_shift;
              po_flag <= 1'b1;
            end else begin
              po_frame_err <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte: line waveforms are built as sample arrays, decoded by a
// software UART model into per-cycle expected outputs, then played and compared.
`timescale 1ns/1ps
module tb_uart_rx_byte;

  localparam int BCM = 16;
`ifdef UART_RX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       rx        = 1'b1;
  logic [7:0] po_data;
  logic       po_flag;
  logic       po_frame_err;

  uart_rx_byte #(
    .CLK_FREQ(160),
    .UART_BPS(10)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .rx          (rx),
    .po_data     (po_data),
    .po_flag     (po_flag),
    .po_frame_err(po_frame_err)
  );

  // ---------------- clock ----------------
  always #5 sys_clk = ~sys_clk;

  // ---------------- model state ----------------
  bit         q_wave[$];
  logic       exp_flag[];
  logic       exp_err[];
  logic [7:0] exp_data[];
  logic [7:0] exp_q[$];
  int         obs_flag_idx[$];
  logic [7:0] obs_data[$];
  int         obs_err_idx[$];
  int         n_checks = 0;
  int         n_errs   = 0;
  int         cur_cyc  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      if (n_errs <= 40)
        $display("FAIL %s cyc=%0d: got 0x%0h expected 0x%0h", name, cur_cyc, act, exp);
    end
  endtask

  // ---------------- wave builders ----------------
  task automatic add_bits(input bit v, input int n);
    for (int i = 0; i < n; i++) q_wave.push_back(v);
  endtask

  task automatic add_frame(input logic [7:0] b, input bit stop_v, input bit par_v);
    add_bits(1'b0, BCM);
    for (int i = 0; i < 8; i++) add_bits(b[i], BCM);
    if (PBITS == 1) add_bits(par_v, BCM);
    add_bits(stop_v, BCM);
  endtask

  task automatic begin_phase();
    q_wave.delete();
    exp_q.delete();
    obs_flag_idx.delete();
    obs_data.delete();
    obs_err_idx.delete();
  endtask

  // Software UART decoder. wave[k] is the line level during cycle k; the receiver
  // sees a fall at k after its 3-flop synchronizer, samples mid-bit at k+7+16*n,
  // and reports 4 cycles after the stop sample. After a frame it can catch a new
  // fall two samples before its report; after a rejected start, 9 samples on.
  task automatic build_exp();
    int         n;
    int         j;
    int         stop_idx;
    int         ev;
    logic [7:0] b;
    bit         pbit;
    bit         prev;
    logic [7:0] cur;
    n = q_wave.size();
    exp_flag = new[n];
    exp_err  = new[n];
    exp_data = new[n];
    for (int k = 0; k < n; k++) begin
      exp_flag[k] = 1'b0;
      exp_err[k]  = 1'b0;
      exp_data[k] = 8'h00;
    end
    j = 0;
    while (j < n) begin
      prev = (j == 0) ? 1'b1 : q_wave[j-1];
      if (prev && !q_wave[j]) begin
        if (j + 7 >= n) break;
        if (q_wave[j+7]) begin
          j = j + 9;
        end else begin
          stop_idx = j + 7 + BCM * (9 + PBITS);
          ev = stop_idx + 4;
          if (ev >= n) break;
          for (int i = 0; i < 8; i++) b[i] = q_wave[j + 7 + BCM * (i + 1)];
          pbit = (PBITS == 1) ? q_wave[j + 7 + BCM * 9] : ^b;
          if (q_wave[stop_idx] && (pbit == ^b)) begin
            exp_flag[ev] = 1'b1;
            exp_data[ev] = b;
            exp_q.push_back(b);
          end else begin
            exp_err[ev] = 1'b1;
          end
          j = ev - 2;
        end
      end else begin
        j++;
      end
    end
    cur = 8'h00;
    for (int k = 0; k < n; k++) begin
      if (exp_flag[k]) cur = exp_data[k];
      exp_data[k] = cur;
    end
  endtask

  // ---------------- driver + compare ----------------
  task automatic play();
    build_exp();
    for (int k = 0; k < q_wave.size(); k++) begin
      @(posedge sys_clk);
      #1 rx = q_wave[k];
      @(negedge sys_clk);
      cur_cyc = k;
      chk("po_flag", 32'(po_flag), 32'(exp_flag[k]));
      chk("po_frame_err", 32'(po_frame_err), 32'(exp_err[k]));
      chk("po_data", 32'(po_data), 32'(exp_data[k]));
      chk("flag_err_excl", 32'(po_flag & po_frame_err), 32'd0);
      if (po_flag === 1'b1) begin
        obs_flag_idx.push_back(k);
        obs_data.push_back(po_data);
        if (exp_q.size() > 0) chk("sb_byte", 32'(po_data), 32'(exp_q.pop_front()));
        else chk("sb_extra", 32'(exp_q.size() > 0), 32'd1);
      end
      if (po_frame_err === 1'b1) obs_err_idx.push_back(k);
    end
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset(input int n, input bit rx_val);
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b0;
    rx = rx_val;
    repeat (n) begin
      @(negedge sys_clk);
      chk("rst_po_data", 32'(po_data), 32'd0);
      chk("rst_po_flag", 32'(po_flag), 32'd0);
      chk("rst_po_frame_err", 32'(po_frame_err), 32'd0);
    end
    #1 sys_rst_n = 1'b1;
    rx = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] b;
    int         r;

    do_reset(4, 1'b1);

    // 1: single 0x55
    begin_phase();
    add_bits(1'b1, 20);
    add_frame(8'h55, 1'b1, ^8'h55);
    add_bits(1'b1, 40);
    play();
    chk("t1_model_flag", 32'(exp_flag[175]), 32'd1);
    chk("t1_model_data", 32'(exp_data[175]), 32'h55);
    chk("t1_nflag", 32'(obs_flag_idx.size()), 32'd1);
    chk("t1_nerr", 32'(obs_err_idx.size()), 32'd0);
    if (obs_flag_idx.size() > 0) begin
      chk("t1_flag_at", 32'(obs_flag_idx[0]), 32'd175);
      chk("t1_data", 32'(obs_data[0]), 32'h55);
    end

    // 2: back-to-back 0x00, 0xFF
    do_reset(3, 1'b1);
    begin_phase();
    add_bits(1'b1, 20);
    add_frame(8'h00, 1'b1, 1'b0);
    add_frame(8'hFF, 1'b1, 1'b0);
    add_bits(1'b1, 40);
    play();
    chk("t2_nflag", 32'(obs_flag_idx.size()), 32'd2);
    if (obs_flag_idx.size() > 1) begin
      chk("t2_first_at", 32'(obs_flag_idx[0]), 32'd175 + 32'(16 * PBITS));
      chk("t2_gap", 32'(obs_flag_idx[1] - obs_flag_idx[0]), 32'd160 + 32'(16 * PBITS));
      chk("t2_data0", 32'(obs_data[0]), 32'h00);
      chk("t2_data1", 32'(obs_data[1]), 32'hFF);
    end

    // 3: glitch, then 0xA3
    do_reset(3, 1'b1);
    begin_phase();
    add_bits(1'b1, 20);
    add_bits(1'b0, 4);
    add_bits(1'b1, 30);
    add_frame(8'hA3, 1'b1, ^8'hA3);
    add_bits(1'b1, 40);
    play();
    chk("t3_nflag", 32'(obs_flag_idx.size()), 32'd1);
    chk("t3_nerr", 32'(obs_err_idx.size()), 32'd0);
    if (obs_flag_idx.size() > 0) begin
      chk("t3_flag_at", 32'(obs_flag_idx[0]), 32'd209 + 32'(16 * PBITS));
      chk("t3_data", 32'(obs_data[0]), 32'hA3);
    end

    // 4: 0x11 good, then 0x3C with stop low; data must hold 0x11
    do_reset(3, 1'b1);
    begin_phase();
    add_bits(1'b1, 10);
    add_frame(8'h11, 1'b1, ^8'h11);
    add_bits(1'b1, 10);
    add_frame(8'h3C, 1'b0, ^8'h3C);
    add_bits(1'b1, 40);
    play();
    chk("t4_nflag", 32'(obs_flag_idx.size()), 32'd1);
    chk("t4_nerr", 32'(obs_err_idx.size()), 32'd1);
    if (obs_err_idx.size() > 0)
      chk("t4_err_at", 32'(obs_err_idx[0]), 32'd335 + 32'(32 * PBITS));
    chk("t4_data_hold", 32'(po_data), 32'h11);

    // break: frame of zeros with stop low, line held low, then recovery
    do_reset(3, 1'b1);
    begin_phase();
    add_bits(1'b1, 10);
    add_frame(8'h00, 1'b0, 1'b0);
    add_bits(1'b0, 200);
    add_bits(1'b1, 20);
    add_frame(8'h42, 1'b1, ^8'h42);
    add_bits(1'b1, 40);
    play();
    chk("brk_nerr", 32'(obs_err_idx.size()), 32'd1);
    chk("brk_nflag", 32'(obs_flag_idx.size()), 32'd1);
    chk("brk_data", 32'(po_data), 32'h42);

    // 5: 0x5A delivered, 0x81 aborted by reset in bit 4, then 0x7E
    do_reset(3, 1'b1);
    begin_phase();
    add_bits(1'b1, 10);
    add_frame(8'h5A, 1'b1, ^8'h5A);
    add_bits(1'b1, 10);
    add_bits(1'b0, BCM);
    b = 8'h81;
    for (int i = 0; i < 4; i++) add_bits(b[i], BCM);
    add_bits(b[4], BCM / 2);
    play();
    chk("t5a_nflag", 32'(obs_flag_idx.size()), 32'd1);
    chk("t5a_data", 32'(po_data), 32'h5A);
    do_reset(5, 1'b0);
    begin_phase();
    add_bits(1'b1, 20);
    add_frame(8'h7E, 1'b1, ^8'h7E);
    add_bits(1'b1, 40);
    play();
    chk("t5b_nflag", 32'(obs_flag_idx.size()), 32'd1);
    chk("t5b_nerr", 32'(obs_err_idx.size()), 32'd0);
    if (obs_flag_idx.size() > 0) begin
      chk("t5b_flag_at", 32'(obs_flag_idx[0]), 32'd175 + 32'(16 * PBITS));
      chk("t5b_data", 32'(obs_data[0]), 32'h7E);
    end

`ifdef UART_RX_PARITY_EN
    // 6: even parity good then bad
    do_reset(3, 1'b1);
    begin_phase();
    add_bits(1'b1, 20);
    add_frame(8'h07, 1'b1, 1'b1);
    add_frame(8'h07, 1'b1, 1'b0);
    add_bits(1'b1, 40);
    play();
    chk("t6_nflag", 32'(obs_flag_idx.size()), 32'd1);
    chk("t6_nerr", 32'(obs_err_idx.size()), 32'd1);
    if (obs_flag_idx.size() > 0) begin
      chk("t6_flag_at", 32'(obs_flag_idx[0]), 32'd191);
      chk("t6_data", 32'(obs_data[0]), 32'h07);
    end
    if (obs_err_idx.size() > 0)
      chk("t6_err_at", 32'(obs_err_idx[0]), 32'd367);
`endif

    // random traffic: bytes, gaps, glitches, bad stop/parity bits
    do_reset(3, 1'b1);
    begin_phase();
    add_bits(1'b1, 20);
    for (int f = 0; f < 16; f++) begin
      b = 8'($urandom_range(0, 255));
      r = $urandom_range(0, 9);
      if (r == 0) begin
        add_bits(1'b0, $urandom_range(1, 6));
        add_bits(1'b1, $urandom_range(10, 30));
      end
      add_frame(b, (r == 1) ? 1'b0 : 1'b1, (^b) ^ (r == 2));
      add_bits(1'b1, $urandom_range(1, 25));
    end
    add_bits(1'b1, 200);
    play();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
UART receiver that deserializes the host byte stream (8N1, LSB first) into one-cycle byte strobes.
It sits directly upstream of the matrix-summing stage: po_data/po_flag drive that stage's pi_data/pi_flag inputs.
The receiver also reports framing errors so the host link can be debugged.

Parameters:
CLK_FREQ, 50_000_000, sys_clk frequency in Hz
UART_BPS, 9600, line baud rate
BAUD_CNT_MAX (localparam), CLK_FREQ/UART_BPS, sys_clk cycles per bit (5208 at defaults)

Ports:
sys_clk  input  1  system clock, all logic on rising edge
sys_rst_n  input  1  asynchronous active-low reset
rx  input  1  asynchronous serial line, idle high
po_data  output  8  last correctly received byte
po_flag  output  1  one-cycle strobe, po_data valid
po_frame_err  output  1  one-cycle strobe, stop bit sampled low (or parity mismatch when the parity feature is compiled in)

Behaviour:
- Reset: the following are all 0:
  - po_data, po_flag, po_frame_err
  - baud counter and bit counter
  - state = IDLE
- Reset sets all three synchronizer flops to 1 (line idle).
- Synchronization:
  - rx passes through 3 flops.
  - A start edge is reg3==1 && reg2==0, detected only in IDLE.
  - Sync latency is 3 cycles.
- Baud counter:
  - Counts 0..BAUD_CNT_MAX-1 and wraps; it is cleared on entry to START.
  - Sample point: baud_cnt == BAUD_CNT_MAX/2 - 1 (mid-bit). All line samples use reg3.
- FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: wait for a start edge, then go to START.
  - START: at the sample point, if the line is 1 it was a glitch: return to IDLE with no strobe. If the line is 0, go to DATA.
  - DATA: at each sample point, shift the sample into bit 7 of the shift register (so the byte ends up LSB first). The bit counter runs 0..7; after bit 7 is sampled, go to STOP.
  - STOP:
    - At the sample point, if the line is 1: po_data <= shift register and po_flag = 1 on the next cycle.
    - If the line is 0: po_frame_err = 1 on the next cycle; po_data is unchanged.
    - Either way, return to IDLE immediately at the stop sample. This leaves half a bit for back-to-back frames to be detected.
- Latency:
  - po_flag asserts 1 cycle after the stop-bit sample.
  - That is about 3 + 9*BAUD_CNT_MAX + BAUD_CNT_MAX/2 cycles after the rx falling edge.
- po_flag and po_frame_err are never high together, and each is exactly 1 cycle wide.
- po_data holds its value until the next valid byte.
- A break condition (line held low) yields one frame error, then stays in IDLE until the line returns high and falls again.
- Reset asserted mid-frame aborts the frame with no strobe. After release, the receiver waits for a fresh high-to-low edge.
- Throughput: one byte per 10 bit times; no buffering is needed because the consumer accepts a byte every cycle.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP, sampled at mid-bit.
  - Parity is even: XOR of the 8 data bits must equal the parity bit.
  - On mismatch, the frame is not delivered (no po_flag) and po_frame_err pulses at the stop-sample timing. The frame-error pulse is generated once per frame.
  - Frame length is 11 bits.
- When undefined: no PARITY state, 8N1 only, and the parity logic is absent.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP)
  - default CLK_FREQ and UART_BPS constants
  - DATA_BITS = 8
- Natural sub-module: uart_baud_gen.
  - Counter plus mid-bit sample strobe, with a clear input.
  - Reusable by the future uart_tx_byte stage, which needs the full-bit strobe.

Test Plan:
1. Bench parameters: CLK_FREQ=160, UART_BPS=10 (BAUD_CNT_MAX=16). Send 0x55 (8N1) -> exactly one po_flag pulse, po_data=0x55, pulse 1 cycle after stop mid-sample, po_frame_err=0.
2. Back-to-back frames 0x00 then 0xFF with zero idle gap -> two po_flag pulses 160 cycles apart, po_data 0x00 then 0xFF.
3. rx low for 4 cycles then high (glitch) -> no po_flag and no po_frame_err; a following frame 0xA3 is received correctly.
4. Frame 0x3C with the stop bit driven 0 -> po_frame_err pulses once, no po_flag, po_data keeps its prior value.
5. Assert sys_rst_n low during bit 4 of frame 0x81, release, then send 0x7E -> no strobe for the aborted frame; 0x7E is received; all outputs read 0 while in reset.
6. With UART_RX_PARITY_EN defined:
   - Send 0x07 with parity bit 1 -> po_flag, po_data=0x07.
   - Send 0x07 with parity bit 0 -> po_frame_err only.
